l1d_refill_ctrl: RTL

//  Miss-refill controller between L1 D-cache miss logic and line-granular memory.

---
 rtl/l1d_refill_ctrl_if.sv | 52 +++++
 rtl/l1d_refill_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/l1d_refill_ctrl_if.sv
// L1 D-cache refill controller bus bundle.
// master: controller side; slave: cache/memory side.
interface l1d_refill_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 512
);
  logic              miss_valid;
  logic              miss_ready;
  logic [ADDR_W-1:0] miss_addr;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid;
  logic [LINE_W-1:0] mem_resp_data;
  logic              fill_valid;
  logic              fill_ready;
  logic [ADDR_W-1:0] fill_addr;
  logic [LINE_W-1:0] fill_data;
  logic              fill_err;
  logic              busy;

  modport master (
    input  miss_valid,
    input  miss_addr,
    input  mem_resp_valid,
    input  mem_resp_data,
    input  fill_ready,
    output miss_ready,
    output mem_req_valid,
    output mem_req_addr,
    output fill_valid,
    output fill_addr,
    output fill_data,
    output fill_err,
    output busy
  );

  modport slave (
    output miss_valid,
    output miss_addr,
    output mem_resp_valid,
    output mem_resp_data,
    output fill_ready,
    input  miss_ready,
    input  mem_req_valid,
    input  mem_req_addr,
    input  fill_valid,
    input  fill_addr,
    input  fill_data,
    input  fill_err,
    input  busy
  );
endinterface

// File: rtl/l1d_refill_ctrl.sv
// L1 D-cache miss refill controller.
// One miss in flight; timeout/retry, error fill when retries run out.
module l1d_refill_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 512,
  parameter int TIMEOUT_CYC = 16,
  parameter int MAX_RETRY   = 2
) (
  input logic               clk,
  input logic               rst_n,
  l1d_refill_ctrl_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYC);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FILL
  } state_e;

  state_e            state_q;
  logic              req_valid_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic              fill_valid_q;
  logic [ADDR_W-1:0] fill_addr_q;
  logic [LINE_W-1:0] fill_data_q;
  logic              fill_err_q;
  logic [TW-1:0]     timer_q;
  logic [RW-1:0]     retry_q;

  logic [ADDR_W-1:0] line_addr_d;
  logic [TW-1:0]     timer_d;
  logic [RW-1:0]     retry_d;

  // Line-aligned miss address and saturating counter increments.
  always_comb begin
    line_addr_d = bus.miss_addr & ~OFF_MASK;
    timer_d     = (timer_q == T_MAX) ? timer_q : timer_q + 1'b1;
    retry_d     = retry_q + 1'b1;
  end

  // Refill FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
      fill_err_q   <= 1'b0;
      timer_q      <= '0;
      retry_q      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.miss_valid) begin
            req_addr_q  <= line_addr_d;
            fill_addr_q <= line_addr_d;
            retry_q     <= '0;
            req_valid_q <= 1'b1;
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          req_valid_q <= 1'b0;
          timer_q     <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          timer_q <= timer_d;
          if (bus.mem_resp_valid) begin
            fill_data_q  <= bus.mem_resp_data;
            fill_err_q   <= 1'b0;
            fill_valid_q <= 1'b1;
            state_q      <= S_FILL;
          end else if (timer_q == T_LAST) begin
            if (retry_q < R_MAX) begin
              retry_q     <= retry_d;
              req_valid_q <= 1'b1;
              state_q     <= S_REQ;
            end else begin
              fill_data_q  <= '0;
              fill_err_q   <= 1'b1;
              fill_valid_q <= 1'b1;
              state_q      <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (bus.fill_ready) begin
            fill_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.miss_ready    = (state_q == S_IDLE);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.fill_valid    = fill_valid_q;
  assign bus.fill_addr     = fill_addr_q;
  assign bus.fill_data     = fill_data_q;
  assign bus.fill_err      = fill_err_q;

endmodule
